crm_div_ctrl: RTL

- Run-time programmable integer clock divider controller for the clock reset module (CRM).
- Sequences start/stop of the divided clock and accepts divide-ratio/duty reconfiguration through a req/ack handshake.
- Applies new settings only at output-period boundaries, so no runt pulses are produced.
- Sits between the CRM register interface and the divided-clock consumers; includes a DFT bypass hook.

---
 rtl/crm_div_pkg.sv | 24 ++
 rtl/crm_div_cnt.sv | 40 ++++
 rtl/crm_div_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/crm_div_pkg.sv
// crm_div_pkg
//   Shared definitions for the CRM programmable clock divider controller:
//   default widths/ratios, the controller state encoding and the
//   ratio/duty legality check used on reconfiguration requests.
package crm_div_pkg;

  localparam int CNT_W_DEFAULT    = 4;
  localparam int DEF_DIV_DEFAULT  = 3;
  localparam int DEF_DUTY_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } crm_div_state_e;

  // A ratio/duty pair is usable only if the output has both a high and a
  // low phase inside every period.
  function automatic logic crm_div_legal(input int unsigned div,
                                         input int unsigned duty);
    return (div >= 2) && (duty >= 1) && (duty < div);
  endfunction

endpackage

// File: rtl/crm_div_cnt.sv
// crm_div_cnt
//   Period counter of the divider. Counts 0..i_div-1 while i_run is high,
//   held at 0 otherwise.
// Ports:
//   clk_i, rst_n_mux   source clock, async active-low reset
//   i_run              controller is in a running state
//   i_div, i_duty      active divide ratio / high-phase length
//   o_clk_next         next value of the registered divided clock
//   o_boundary         last cycle of the current output period
//   o_period_start     first cycle of the current output period
module crm_div_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_mux,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_clk_next,
  output logic             o_boundary,
  output logic             o_period_start
);

  logic [CNT_W-1:0] r_cnt;

  assign o_boundary     = i_run && (r_cnt == (i_div - 1'b1));
  assign o_period_start = i_run && (r_cnt == '0);
  assign o_clk_next     = i_run && (r_cnt < i_duty);

  always_ff @(posedge clk_i or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      r_cnt <= '0;
    end else if (!i_run || o_boundary) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/crm_div_ctrl.sv
// crm_div_ctrl
//   Run-time programmable integer clock divider controller for the CRM.
//   Starts/stops the divided clock on en_i and accepts ratio/duty changes
//   through a req/ack handshake. New settings and stops only take effect at
//   an output-period boundary, so the divided clock never produces a runt.
//
//   Optional build macro CRM_DIV_TEST_BYPASS_EN: when defined, test_mode=1
//   routes clk_i straight to clk_o through the clock mux; the counter, FSM
//   and handshake keep operating. When undefined, test_mode is ignored.
//
// Ports:
//   clk_i           source clock
//   rst_n_mux       async active-low reset (already muxed with test reset)
//   en_i            run request (level)
//   cfg_req_i       reconfiguration request, held until cfg_ack_o
//   cfg_div_i       requested divide ratio
//   cfg_duty_i      requested high-phase length
//   cfg_ack_o       one-cycle ack, request consumed
//   cfg_err_o       with cfg_ack_o: request was illegal, config unchanged
//   test_mode       DFT bypass select
//   clk_o           divided clock (registered)
//   running_o       divider in RUN or PEND
//   period_start_o  first cycle of an output period while running
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | counter held at 0, clk_o low, config writes apply directly
// RUN   | counter running with the current config
// PEND  | running; a legal config is latched, applied at the boundary
module crm_div_ctrl
  import crm_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DEF_DIV  = DEF_DIV_DEFAULT,
  parameter int DEF_DUTY = DEF_DUTY_DEFAULT,
  parameter int START_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_mux,
  input  logic             en_i,
  input  logic             cfg_req_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_duty_i,
  output logic             cfg_ack_o,
  output logic             cfg_err_o,
  input  logic             test_mode,
  output logic             clk_o,
  output logic             running_o,
  output logic             period_start_o
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_PEND = ST_PEND;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_cur_duty;
  logic [CNT_W-1:0] r_pend_div;
  logic [CNT_W-1:0] r_pend_duty;
  logic             r_ack;
  logic             r_err;
  logic             r_clk_div;
  logic             r_armed;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cur_div_nxt;
  logic [CNT_W-1:0] w_cur_duty_nxt;
  logic [CNT_W-1:0] w_pend_div_nxt;
  logic [CNT_W-1:0] w_pend_duty_nxt;
  logic             w_ack_nxt;
  logic             w_err_nxt;
  logic             w_running;
  logic             w_req;
  logic             w_legal;
  logic             w_clk_next;
  logic             w_boundary;
  logic             w_period_start;

  assign w_running = (r_state != S_IDLE);
  // The cycle carrying an ack is not a new request; a request still high
  // one cycle later is.
  assign w_req     = cfg_req_i && !r_ack;
  assign w_legal   = crm_div_legal(32'(cfg_div_i), 32'(cfg_duty_i));

  crm_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i          (clk_i),
    .rst_n_mux      (rst_n_mux),
    .i_run          (w_running),
    .i_div          (r_cur_div),
    .i_duty         (r_cur_duty),
    .o_clk_next     (w_clk_next),
    .o_boundary     (w_boundary),
    .o_period_start (w_period_start)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_div_nxt   = r_cur_div;
    w_cur_duty_nxt  = r_cur_duty;
    w_pend_div_nxt  = r_pend_div;
    w_pend_duty_nxt = r_pend_duty;
    w_ack_nxt       = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_ack_nxt = 1'b1;
          if (w_legal) begin
            w_cur_div_nxt  = cfg_div_i;
            w_cur_duty_nxt = cfg_duty_i;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        if (en_i && r_armed) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_req && !w_legal) begin
          w_ack_nxt = 1'b1;
          w_err_nxt = 1'b1;
        end
        // A legal request arriving on the stopping edge is left waiting and
        // is taken directly from IDLE on the next edge.
        if (w_boundary && !en_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_req && w_legal) begin
          w_pend_div_nxt  = cfg_div_i;
          w_pend_duty_nxt = cfg_duty_i;
          w_state_nxt     = S_PEND;
        end
      end
      S_PEND: begin
        if (w_boundary) begin
          w_cur_div_nxt  = r_pend_div;
          w_cur_duty_nxt = r_pend_duty;
          w_ack_nxt      = 1'b1;
          w_state_nxt    = en_i ? S_RUN : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      r_state     <= S_IDLE;
      r_cur_div   <= CNT_W'(DEF_DIV);
      r_cur_duty  <= CNT_W'(DEF_DUTY);
      r_pend_div  <= '0;
      r_pend_duty <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_clk_div   <= 1'b0;
      r_armed     <= (START_EN != 0);
    end else begin
      r_state     <= w_state_nxt;
      r_cur_div   <= w_cur_div_nxt;
      r_cur_duty  <= w_cur_duty_nxt;
      r_pend_div  <= w_pend_div_nxt;
      r_pend_duty <= w_pend_duty_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_clk_div   <= w_clk_next;
      // Without auto-start, en_i must be seen low once so that a level held
      // high through reset does not count as a start.
      if (!en_i) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign cfg_ack_o      = r_ack;
  assign cfg_err_o      = r_err;
  assign running_o      = w_running;
  assign period_start_o = w_period_start;

`ifdef CRM_DIV_TEST_BYPASS_EN
  // Behavioural view of the glitch-safe clock mux; the netlist uses the
  // library clock-mux cell here.
  assign clk_o = test_mode ? clk_i : r_clk_div;
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
  assign clk_o = r_clk_div;
`endif

endmodule
